progmem_responder: RTL and testbench
====================================

Name: progmem_responder

Overview:
- Memory-side responder for the CPU's instruction/data bus: the CPU drives the address and a read strobe, and this block returns read data.
- Holds a word-organised RAM and returns registered read data one cycle after the strobe.
- Accepts byte-lane-masked writes for future load/store support.
- Contains a byte-serial boot loader that assembles little-endian bytes into words and fills the RAM before the CPU is released.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words in the RAM.
- ADDR_W, 8, word-index bits; must equal log2(DEPTH_WORDS).
- BOOT_EN, 1, 1 = loader active after reset; 0 = block starts in DONE with the loader disabled.

Ports:
- clk  in  1  system clock, all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_addr  in  32  byte address from CPU; bits [1:0] ignored.
- mem_rstrb  in  1  read strobe, sampled on the clock edge.
- mem_rdata  out  32  registered read data.
- mem_rvalid  out  1  high for exactly one cycle when mem_rdata is updated by a read.
- mem_wdata  in  32  write data.
- mem_wmask  in  4  byte-lane write enables; bit i controls bits [8i+7:8i].
- load_valid  in  1  boot byte present.
- load_byte  in  8  boot byte.
- load_last  in  1  qualifies the final boot byte.
- load_ready  out  1  loader can accept a byte this cycle.
- load_done  out  1  loading complete; the CPU may leave reset.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high, ports named clk and rst.
- Reset values: mem_rdata = 0, mem_rvalid = 0, load_done = !BOOT_EN, load_ready = BOOT_EN, loader pointer = 0, loader state = B0 (or DONE if BOOT_EN = 0).
- Reset does not clear RAM contents. Reset mid-load restarts at B0 with pointer 0; words already written remain.
- Address decode: idx = mem_addr[ADDR_W+1:2]. The address is out of range when mem_addr[31:ADDR_W+2] != 0.
- Out-of-range reads return 0 with mem_rvalid still asserted. Out-of-range writes are ignored.
- Read:
  - Edge with mem_rstrb = 1 and state = DONE: mem_rdata <= ram[idx], mem_rvalid <= 1.
  - Otherwise mem_rvalid <= 0 and mem_rdata holds its value.
  - Latency is 1 cycle. The CPU's one-cycle WAIT before FETCH matches this.
- Write:
  - Edge with state = DONE: each lane i with mem_wmask[i] = 1 is written.
  - Read and write to the same word in the same cycle: the read returns the OLD data (read-before-write).
- Loader FSM states: B0, B1, B2, B3, DONE.
  - load_ready = 1 in B0–B3 and 0 in DONE. load_done = (state == DONE), registered through the state.
  - Byte accepted on an edge with load_valid & load_ready. B0 captures lane 0, B1 lane 1, B2 lane 2, B3 lane 3.
  - Acceptance in Bn advances to Bn+1; acceptance in B3 returns to B0.
  - Acceptance in B3 writes the assembled word {b3,b2,b1,b0} to ram[ptr] on that edge, then ptr increments.
  - load_last accepted in any Bn: write the partial word with unfilled upper lanes = 0, then go to DONE.
  - ptr reaching DEPTH_WORDS-1 and being written: go to DONE. No wrap-around; excess bytes are never accepted.
  - No acceptance: state holds. load_last without load_valid has no effect.
  - DONE is left only by rst.
- While not in DONE: CPU strobes and masks are ignored, and mem_rvalid stays 0. The loader has exclusive RAM access.
- System rule: the top level holds the CPU in rst while load_done = 0.

Decomposition:
- Shared package:
  - loader state encoding (B0..B3, DONE);
  - BYTE_LANES = 4;
  - the word-index slice helper constant.
- Sub-module progmem_loader: the FSM, byte shift register, and pointer. It outputs a write request (we, idx, 32-bit word).
- The top block contains the RAM array, address decode, the read/write port, and the mux between loader and CPU access.

Test Plan:
- Boot fill: bytes 0x13,0x05,0x10,0x00 then 0x73,0x00,0x10,0x00 with load_last on the final byte -> ram[0] = 0x00100513, ram[1] = 0x00100073, load_done rises the cycle after, load_ready = 0.
- Read latency: after DONE, mem_rstrb = 1 with mem_addr = 0x4 -> next cycle mem_rdata = 0x00100073 and mem_rvalid = 1 for exactly one cycle; the strobe's cycle shows mem_rvalid = 0.
- Partial word and masked write: load bytes 0xAA,0xBB with load_last -> ram[0] = 0x0000BBAA. Then write mem_wdata = 0x11223344, wmask = 4'b0101 at addr 0 -> a read gives 0x0022BB44.
- Read/write collision: rstrb and wmask = 4'hF at addr 0x8 holding 0xDEADBEEF, wdata = 0x1 -> mem_rdata = 0xDEADBEEF; the next read gives 0x00000001.
- Gating and range: rstrb during loading -> mem_rvalid stays 0. Read at addr 0x400 with DEPTH_WORDS = 256 -> mem_rdata = 0, mem_rvalid = 1.
- Reset mid-load: 2 bytes accepted, then rst for 1 cycle -> state B0, load_ready = 1, load_done = 0. New bytes 0x01..0x04 -> ram[0] = 0x04030201.

Source files
------------

// File: rtl/progmem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : progmem_responder_pkg
// Purpose  : Shared definitions for the program-memory responder: the boot
//            loader state encoding, byte-lane count and the position of the
//            word index inside a CPU byte address.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package progmem_responder_pkg;

  // Number of byte lanes in one RAM word.
  localparam int unsigned BYTE_LANES = 4;

  // The word index starts just above the byte-offset bits of a CPU address.
  localparam int unsigned WORD_LSB = 2;

  // Boot loader states: B0..B3 expect the byte for that lane, DONE hands the
  // RAM over to the CPU.
  typedef enum logic [2:0] {
    LD_B0   = 3'd0,
    LD_B1   = 3'd1,
    LD_B2   = 3'd2,
    LD_B3   = 3'd3,
    LD_DONE = 3'd4
  } ld_state_e;

endpackage : progmem_responder_pkg
`default_nettype wire

// File: rtl/progmem_responder_loader.sv
`default_nettype none
// ============================================================================
// Module   : progmem_loader
// Purpose  : Byte-serial boot loader. Collects little-endian bytes into
//            32-bit words and issues one RAM write per completed (or final
//            partial) word. Stops after load_last or after the last RAM word.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            load_valid_i      - boot byte present
//            load_byte_i       - boot byte
//            load_last_i       - qualifies the final boot byte
//            load_ready_o      - loader can accept a byte (registered)
//            load_done_o       - loading complete (registered)
//            we_o/widx_o/wword_o - full-word RAM write request, valid on the
//                                accepting edge
// Revision : 1.0 - initial release
// ============================================================================
module progmem_loader
  import progmem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned ADDR_W      = 8,
  parameter bit          BOOT_EN     = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_valid_i,
  input  logic [7:0]        load_byte_i,
  input  logic              load_last_i,
  output logic              load_ready_o,
  output logic              load_done_o,
  output logic              we_o,
  output logic [ADDR_W-1:0] widx_o,
  output logic [31:0]       wword_o
);

  localparam logic [ADDR_W-1:0] PTR_MAX = ADDR_W'(DEPTH_WORDS - 1);

  ld_state_e         state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [23:0]       bytes_q;   // lanes 0..2 of the word being assembled
  logic              ready_q;
  logic              done_q;

  logic              accept_d;
  logic              we_d;
  logic [31:0]       word_d;

  // Assemble the word as it would look if written on this edge. Lanes above
  // the current one are forced to zero so a load_last partial word never
  // carries stale bytes from the previous word.
  always_comb begin
    accept_d = load_valid_i && ready_q;
    word_d   = 32'h0;
    case (state_q)
      LD_B0:   word_d = {24'h0, load_byte_i};
      LD_B1:   word_d = {16'h0, load_byte_i, bytes_q[7:0]};
      LD_B2:   word_d = {8'h0,  load_byte_i, bytes_q[15:0]};
      LD_B3:   word_d = {load_byte_i, bytes_q[23:0]};
      default: word_d = 32'h0;
    endcase
    we_d = accept_d && ((state_q == LD_B3) || load_last_i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BOOT_EN ? LD_B0 : LD_DONE;
      ptr_q   <= '0;
      bytes_q <= '0;
      ready_q <= BOOT_EN;
      done_q  <= !BOOT_EN;
    end else if (accept_d) begin
      if (we_d) begin
        if (load_last_i || (ptr_q == PTR_MAX)) begin
          // No wrap-around: once the final word is written the loader stops.
          state_q <= LD_DONE;
          ready_q <= 1'b0;
          done_q  <= 1'b1;
        end else begin
          state_q <= LD_B0;
          ptr_q   <= ptr_q + 1'b1;
        end
      end else begin
        case (state_q)
          LD_B0: begin
            bytes_q[7:0] <= load_byte_i;
            state_q      <= LD_B1;
          end
          LD_B1: begin
            bytes_q[15:8] <= load_byte_i;
            state_q       <= LD_B2;
          end
          LD_B2: begin
            bytes_q[23:16] <= load_byte_i;
            state_q        <= LD_B3;
          end
          default: state_q <= state_q;
        endcase
      end
    end
  end

  assign load_ready_o = ready_q;
  assign load_done_o  = done_q;
  assign we_o         = we_d;
  assign widx_o       = ptr_q;
  assign wword_o      = word_d;

endmodule : progmem_loader
`default_nettype wire

// File: rtl/progmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : progmem_responder
// Purpose  : Memory-side responder for the CPU instruction/data bus. Word
//            RAM with registered reads (1-cycle latency), byte-masked writes,
//            and a byte-serial boot loader that owns the RAM until done.
// Ports    : clk, rst                 - clock, synchronous active-high reset
//            mem_addr/mem_rstrb       - CPU byte address and read strobe
//            mem_rdata/mem_rvalid     - registered read data and valid pulse
//            mem_wdata/mem_wmask      - CPU write data and byte-lane enables
//            load_valid/byte/last     - boot byte stream
//            load_ready/load_done     - loader handshake and completion
// Revision : 1.0 - initial release
// ============================================================================
module progmem_responder
  import progmem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned ADDR_W      = 8,
  parameter bit          BOOT_EN     = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_addr,
  input  logic        mem_rstrb,
  output logic [31:0] mem_rdata,
  output logic        mem_rvalid,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wmask,
  input  logic        load_valid,
  input  logic [7:0]  load_byte,
  input  logic        load_last,
  output logic        load_ready,
  output logic        load_done
);

  logic [31:0]           mem_q [DEPTH_WORDS];
  logic [31:0]           rdata_q;
  logic                  rvalid_q;

  logic                  ld_we;
  logic [ADDR_W-1:0]     ld_idx;
  logic [31:0]           ld_word;
  logic                  ld_done;

  logic [ADDR_W-1:0]     cpu_idx_d;
  logic                  in_range_d;
  logic [BYTE_LANES-1:0] lane_we_d;
  logic [ADDR_W-1:0]     wr_idx_d;
  logic [31:0]           wr_data_d;
  logic                  addr_unused;

  progmem_loader #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .ADDR_W      (ADDR_W),
    .BOOT_EN     (BOOT_EN)
  ) u_loader (
    .clk          (clk),
    .rst          (rst),
    .load_valid_i (load_valid),
    .load_byte_i  (load_byte),
    .load_last_i  (load_last),
    .load_ready_o (load_ready),
    .load_done_o  (ld_done),
    .we_o         (ld_we),
    .widx_o       (ld_idx),
    .wword_o      (ld_word)
  );

  // Byte offset bits do not take part in word addressing.
  assign addr_unused = ^mem_addr[WORD_LSB-1:0];

  assign cpu_idx_d  = mem_addr[ADDR_W+WORD_LSB-1:WORD_LSB];
  assign in_range_d = (mem_addr[31:ADDR_W+WORD_LSB] == '0);

  // Single write port: the loader owns it until done, then the CPU.
  always_comb begin
    lane_we_d = '0;
    wr_idx_d  = '0;
    wr_data_d = '0;
    if (!ld_done) begin
      if (ld_we) begin
        lane_we_d = '1;
        wr_idx_d  = ld_idx;
        wr_data_d = ld_word;
      end
    end else if (in_range_d) begin
      lane_we_d = mem_wmask;
      wr_idx_d  = cpu_idx_d;
      wr_data_d = mem_wdata;
    end
  end

  // RAM contents survive reset, so this block has no reset branch.
  always_ff @(posedge clk) begin
    for (int i = 0; i < BYTE_LANES; i++) begin
      if (lane_we_d[i]) begin
        mem_q[wr_idx_d][8*i +: 8] <= wr_data_d[8*i +: 8];
      end
    end
  end

  // The read samples mem_q before this edge's write lands, giving
  // read-before-write on a same-word collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else if (mem_rstrb && ld_done) begin
      rdata_q  <= in_range_d ? mem_q[cpu_idx_d] : 32'h0;
      rvalid_q <= 1'b1;
    end else begin
      rvalid_q <= 1'b0;
    end
  end

  assign mem_rdata  = rdata_q;
  assign mem_rvalid = rvalid_q;
  assign load_done  = ld_done;

endmodule : progmem_responder
`default_nettype wire

// File: tb/tb_progmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_progmem_responder
// Purpose  : Self-checking bench for progmem_responder. A behavioural model
//            tracks RAM contents, loader progress and read responses; a
//            compare process checks every cycle, and directed scenarios add
//            literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_progmem_responder;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] mem_addr = '0;
  logic        mem_rstrb = 1'b0;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_wmask = '0;
  logic        load_valid = 1'b0;
  logic [7:0]  load_byte = '0;
  logic        load_last = 1'b0;
  logic        load_ready;
  logic        load_done;

  int n_checks = 0;
  int n_errors = 0;

  progmem_responder #(
    .DEPTH_WORDS (DEPTH),
    .ADDR_W      (8),
    .BOOT_EN     (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_addr   (mem_addr),
    .mem_rstrb  (mem_rstrb),
    .mem_rdata  (mem_rdata),
    .mem_rvalid (mem_rvalid),
    .mem_wdata  (mem_wdata),
    .mem_wmask  (mem_wmask),
    .load_valid (load_valid),
    .load_byte  (load_byte),
    .load_last  (load_last),
    .load_ready (load_ready),
    .load_done  (load_done)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [31:0] m_ram [DEPTH];
  logic [7:0]  m_bytes [4];
  int          m_cnt = 0;
  int          m_ptr = 0;
  bit          m_done = 0;
  bit          m_rvalid = 0;
  logic [31:0] m_rdata = '0;
  bit          started = 0;

  always @(posedge clk) begin
    logic [31:0] w;
    bit          oor;
    if (rst) begin
      m_done = 0; m_cnt = 0; m_ptr = 0; m_rvalid = 0; m_rdata = '0;
      started = 1;
    end else begin
      oor = (mem_addr[31:10] != 0);
      if (m_done && mem_rstrb) begin
        m_rvalid = 1;
        m_rdata  = oor ? 32'h0 : m_ram[mem_addr[9:2]];
      end else begin
        m_rvalid = 0;
      end
      if (m_done) begin
        if (!oor)
          for (int k = 0; k < 4; k++)
            if (mem_wmask[k]) m_ram[mem_addr[9:2]][8*k +: 8] = mem_wdata[8*k +: 8];
      end else if (load_valid) begin
        m_bytes[m_cnt] = load_byte;
        m_cnt++;
        if (m_cnt == 4 || load_last) begin
          w = '0;
          for (int k = 0; k < m_cnt; k++) w = w | (32'(m_bytes[k]) << (8*k));
          m_ram[m_ptr] = w;
          if (load_last || m_ptr == DEPTH-1) m_done = 1;
          m_ptr++;
          m_cnt = 0;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (started) begin
      check("rvalid", {31'h0, mem_rvalid}, {31'h0, m_rvalid});
      check("rdata", mem_rdata, m_rdata);
      check("load_ready", {31'h0, load_ready}, {31'h0, !m_done});
      check("load_done", {31'h0, load_done}, {31'h0, m_done});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) cyc();
    rst = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    load_valid = 1'b1; load_byte = b; load_last = last;
    cyc();
    load_valid = 1'b0; load_last = 1'b0;
  endtask

  task automatic cpu_read(input logic [31:0] a);
    mem_addr = a; mem_rstrb = 1'b1;
    cyc();
    mem_rstrb = 1'b0;
  endtask

  task automatic cpu_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    mem_addr = a; mem_wdata = d; mem_wmask = m;
    cyc();
    mem_wmask = 4'h0;
  endtask

  initial begin
    logic [7:0] boot [8];
    boot = '{8'h13, 8'h05, 8'h10, 8'h00, 8'h73, 8'h00, 8'h10, 8'h00};

    do_reset(2);
    check("reset ready", {31'h0, load_ready}, 32'h1);
    check("reset done", {31'h0, load_done}, 32'h0);
    check("reset rdata", mem_rdata, 32'h0);

    // Strobe during loading must be ignored.
    mem_rstrb = 1'b1; mem_addr = 32'h0;
    send_byte(boot[0], 1'b0);
    mem_rstrb = 1'b0;
    check("rvalid gated", {31'h0, mem_rvalid}, 32'h0);
    for (int i = 1; i < 8; i++) send_byte(boot[i], (i == 7));
    check("boot done", {31'h0, load_done}, 32'h1);
    check("boot ready", {31'h0, load_ready}, 32'h0);
    check("model w0", m_ram[0], 32'h00100513);
    check("model w1", m_ram[1], 32'h00100073);

    // Read latency: one cycle, single-cycle valid pulse.
    cpu_read(32'h4);
    check("read 4 data", mem_rdata, 32'h00100073);
    check("read 4 valid", {31'h0, mem_rvalid}, 32'h1);
    cyc();
    check("valid pulse", {31'h0, mem_rvalid}, 32'h0);
    cpu_read(32'h0);
    check("read 0 data", mem_rdata, 32'h00100513);

    // Out-of-range read and ignored out-of-range write (would alias idx 0).
    cpu_read(32'h400);
    check("oor data", mem_rdata, 32'h0);
    check("oor valid", {31'h0, mem_rvalid}, 32'h1);
    cpu_write(32'h400, 32'hFFFFFFFF, 4'hF);
    cpu_read(32'h0);
    check("oor write ignored", mem_rdata, 32'h00100513);

    // Read/write collision: old data first, new data on the next read.
    cpu_write(32'h8, 32'hDEADBEEF, 4'hF);
    mem_addr = 32'h8; mem_rstrb = 1'b1; mem_wdata = 32'h1; mem_wmask = 4'hF;
    cyc();
    mem_rstrb = 1'b0; mem_wmask = 4'h0;
    check("collision old", mem_rdata, 32'hDEADBEEF);
    cpu_read(32'h8);
    check("collision new", mem_rdata, 32'h00000001);

    // Reset mid-load, load_last without load_valid, then a fresh word.
    do_reset(1);
    send_byte(8'h55, 1'b0);
    send_byte(8'h66, 1'b0);
    do_reset(1);
    check("midload ready", {31'h0, load_ready}, 32'h1);
    check("midload done", {31'h0, load_done}, 32'h0);
    load_last = 1'b1;
    cyc();
    load_last = 1'b0;
    check("lone last", {31'h0, load_done}, 32'h0);
    for (int i = 1; i <= 4; i++) send_byte(8'(i), (i == 4));
    cpu_read(32'h0);
    check("restart word", mem_rdata, 32'h04030201);

    // Partial word then masked write.
    do_reset(1);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b1);
    cpu_read(32'h0);
    check("partial word", mem_rdata, 32'h0000BBAA);
    cpu_write(32'h0, 32'h11223344, 4'b0101);
    cpu_read(32'h0);
    check("masked write", mem_rdata, 32'h0022BB44);

    // Full fill without load_last: stops at the last word, no wrap.
    do_reset(1);
    for (int k = 0; k < DEPTH*4; k++) begin
      int v;
      v = (k & 255) ^ (k >> 8);
      send_byte(8'(v), 1'b0);
    end
    check("fill done", {31'h0, load_done}, 32'h1);
    send_byte(8'h99, 1'b0);
    check("fill ready", {31'h0, load_ready}, 32'h0);
    cpu_read(32'h3FC);
    check("fill last word", mem_rdata, 32'hFCFDFEFF);
    cpu_read(32'h0);
    check("fill first word", mem_rdata, 32'h03020100);
    cyc();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_progmem_responder
`default_nettype wire
